// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin word-mux arbiter.
// Holds the grant FSM encoding and the pointer-advance rule.
package mux_rr_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Pointer after serving requester g: one past it, modulo 2**wlog.
    function automatic int unsigned rr_next(
        input int unsigned g,
        input int unsigned wlog
    );
        return (g + 1) % (32'd1 << wlog);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first active request at or after ptr.
// Purely combinational; wraps past the top index back to zero.
module rr_pick #(
    parameter int WLOG = 5
) (
    input  logic [2**WLOG-1:0] req,
    input  logic [WLOG-1:0]    ptr,
    output logic [WLOG-1:0]    gnt_idx,
    output logic               gnt_vld
);

    logic [WLOG-1:0] idx;

    // Walk offsets from far to near so the nearest request wins.
    always_comb begin
        gnt_idx = ptr;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 2**WLOG - 1; i >= 0; i--) begin
            idx = ptr + WLOG'(i);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared N-to-1 word mux into one
// registered valid/ready output stage, with per-packet grant lock.
module mux_rr_arbiter
    import mux_rr_pkg::*;
#(
    parameter int WLOG   = 5,
    parameter int WWIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [2**WLOG-1:0]               req,
    input  logic [2**WLOG-1:0]               last,
    input  logic [2**WLOG-1:0][WWIDTH-1:0]   data,
    output logic [2**WLOG-1:0]               ack,
    output logic [WWIDTH-1:0]                out_data,
    output logic [WWIDTH-1:0]                out_data_neg,
    output logic [WLOG-1:0]                  out_sel,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready
);

    state_t          state;
    state_t          state_d;
    logic [WLOG-1:0] ptr;
    logic [WLOG-1:0] ptr_d;
    logic [WLOG-1:0] lock_idx;
    logic [WLOG-1:0] lock_d;

    logic [WLOG-1:0] pick_idx;
    logic            pick_vld;
    logic [WLOG-1:0] gnt_idx;
    logic            gnt_vld;
    logic            gnt_last;
    logic            can_accept;
    logic            accept;

    rr_pick #(
        .WLOG(WLOG)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .gnt_idx(pick_idx),
        .gnt_vld(pick_vld)
    );

    // A locked packet owns the mux; everyone else is ignored.
    always_comb begin
        gnt_idx = pick_idx;
        gnt_vld = pick_vld;
        if (state == LOCKED) begin
            gnt_idx = lock_idx;
            gnt_vld = req[lock_idx];
        end
    end

    assign can_accept = !out_valid || out_ready;
    assign accept     = gnt_vld && can_accept && rst_n;
    assign gnt_last   = last[gnt_idx];

    always_comb begin
        ack = '0;
        if (accept) begin
            ack[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        lock_d  = lock_idx;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (gnt_last) begin
                        ptr_d = WLOG'(rr_next(32'(gnt_idx), WLOG));
                    end else begin
                        state_d = LOCKED;
                        lock_d  = gnt_idx;
                    end
                end
                LOCKED: begin
                    if (gnt_last) begin
                        state_d = IDLE;
                        ptr_d   = WLOG'(rr_next(32'(lock_idx), WLOG));
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            lock_idx <= lock_d;
        end
    end

    // Output stage: replace on accept, drain on handshake otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= data[gnt_idx];
            out_sel   <= gnt_idx;
            out_last  <= gnt_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_data_neg = ~out_data;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter with a queue-free
// behavioural model of the round-robin and packet-lock rules.
module tb_mux_rr_arbiter;

    localparam int WLOG = 2;
    localparam int N    = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N-1:0]      last;
    logic [N-1:0][W-1:0] data;
    logic [N-1:0]      ack;
    logic [W-1:0]      out_data;
    logic [W-1:0]      out_data_neg;
    logic [WLOG-1:0]   out_sel;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    int tests = 0;
    int fails = 0;

    int       m_ptr;
    bit       m_locked;
    int       m_lock;
    logic     m_ov;
    logic [7:0] m_od;
    int       m_os;
    logic     m_ol;

    mux_rr_arbiter #(
        .WLOG  (WLOG),
        .WWIDTH(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .last        (last),
        .data        (data),
        .ack         (ack),
        .out_data    (out_data),
        .out_data_neg(out_data_neg),
        .out_sel     (out_sel),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_ptr    = 0;
        m_locked = 0;
        m_lock   = 0;
        m_ov     = 1'b0;
        m_od     = 8'h00;
        m_os     = 0;
        m_ol     = 1'b0;
    endfunction

    function automatic int model_grant();
        if (m_locked) return req[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ack();
        int g;
        g = model_grant();
        if (g >= 0 && (!m_ov || out_ready) && rst_n)
            return 4'(1 << g);
        return '0;
    endfunction

    task automatic tick();
        int g;
        g = model_grant();
        if (g >= 0 && (!m_ov || out_ready) && rst_n) begin
            m_od = data[g];
            m_os = g;
            m_ol = last[g];
            m_ov = 1'b1;
            if (!m_locked) begin
                if (last[g]) m_ptr = (g + 1) % N;
                else begin
                    m_locked = 1;
                    m_lock   = g;
                end
            end else if (last[g]) begin
                m_locked = 0;
                m_ptr    = (g + 1) % N;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req       = 4'($urandom);
            last      = 4'($urandom);
            data      = $urandom;
            out_ready = 1'($urandom);
            #1;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL rst_valid got %b want 0", out_valid);
            end
            tests++;
            if (out_data !== 8'h00 || out_data_neg !== 8'hFF) begin
                fails++;
                $display("FAIL rst_data got %h/%h want 00/ff",
                         out_data, out_data_neg);
            end
            tests++;
            if (out_sel !== 2'd0 || ack !== 4'b0000) begin
                fails++;
                $display("FAIL rst_sel_ack got %0d/%b want 0/0000",
                         out_sel, ack);
            end
        end
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fair_rotation();
        logic [7:0] exp;
        out_ready = 1'b1;
        req       = 4'b1111;
        last      = 4'b1111;
        for (int i = 0; i < N; i++) data[i] = 8'(8'h10 + i);
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++;
            if (ack !== model_ack()) begin
                fails++;
                $display("FAIL rot_ack got %b want %b", ack, model_ack());
            end
            tick();
            exp = 8'(8'h10 + k % N);
            tests++;
            if (out_data !== exp || out_sel !== 2'(k % N)) begin
                fails++;
                $display("FAIL rot_out got %h/%0d want %h/%0d",
                         out_data, out_sel, exp, k % N);
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] exp;
        do_reset();
        out_ready = 1'b1;
        req       = 4'b0011;
        last      = 4'b0010;
        data[1]   = 8'hB0;
        for (int k = 0; k < 4; k++) begin
            data[0] = 8'(8'hA0 + k);
            last[0] = (k == 2);
            if (k == 3) req[0] = 1'b0;
            #1;
            tests++;
            if ((k < 3 && ack[1] !== 1'b0) || ack !== model_ack()) begin
                fails++;
                $display("FAIL lock_ack got %b want %b", ack, model_ack());
            end
            tick();
            exp = (k < 3) ? 8'(8'hA0 + k) : 8'hB0;
            tests++;
            if (out_data !== exp || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL lock_out got %h want %h", out_data, exp);
            end
        end
        req = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        last      = 4'b1111;
        req       = 4'b0010;
        data[1]   = 8'h11;
        #1;
        tests++;
        if (ack !== 4'b0010) begin
            fails++;
            $display("FAIL bp_first_ack got %b want 0010", ack);
        end
        tick();
        out_ready = 1'b0;
        req       = 4'b0110;
        data[1]   = 8'h21;
        data[2]   = 8'h22;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (ack !== 4'b0000) begin
                fails++;
                $display("FAIL bp_ack got %b want 0000", ack);
            end
            tick();
            tests++;
            if (out_data !== 8'h11 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold got %h/%b want 11/1",
                         out_data, out_valid);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (ack !== 4'b0100) begin
            fails++;
            $display("FAIL bp_release_ack got %b want 0100", ack);
        end
        tick();
        tests++;
        if (out_sel !== 2'd2 || out_data !== 8'h22) begin
            fails++;
            $display("FAIL bp_release_out got %0d/%h want 2/22",
                     out_sel, out_data);
        end
        req = '0;
    endtask

    task automatic test_sparse_wrap();
        do_reset();
        out_ready = 1'b1;
        last      = 4'b1111;
        req       = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            data[2] = 8'(8'h30 + k);
            #1;
            tests++;
            if (ack !== 4'b0100) begin
                fails++;
                $display("FAIL sparse_ack got %b want 0100", ack);
            end
            tick();
            tests++;
            if (out_sel !== 2'd2 || out_data !== 8'(8'h30 + k)) begin
                fails++;
                $display("FAIL sparse_out got %0d/%h want 2/%h",
                         out_sel, out_data, 8'(8'h30 + k));
            end
        end
        req     = 4'b1010;
        data[1] = 8'h41;
        data[3] = 8'h43;
        #1;
        tests++;
        if (ack !== 4'b1000) begin
            fails++;
            $display("FAIL wrap_ack3 got %b want 1000", ack);
        end
        tick();
        tests++;
        if (out_sel !== 2'd3) begin
            fails++;
            $display("FAIL wrap_sel3 got %0d want 3", out_sel);
        end
        #1;
        tests++;
        if (ack !== 4'b0010) begin
            fails++;
            $display("FAIL wrap_ack1 got %b want 0010", ack);
        end
        tick();
        tests++;
        if (out_sel !== 2'd1 || out_data !== 8'h41) begin
            fails++;
            $display("FAIL wrap_sel1 got %0d/%h want 1/41",
                     out_sel, out_data);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        out_ready = 1'b1;
        req       = 4'b0010;
        last      = 4'b0000;
        data[1]   = 8'h55;
        #1;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL mid_beat got %b/%b want 1/0", out_valid, out_last);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || ack !== 4'b0000) begin
            fails++;
            $display("FAIL mid_rst got %b/%b want 0/0000", out_valid, ack);
        end
        rst_n = 1'b1;
        model_reset();
        req     = 4'b0101;
        last    = 4'b1111;
        data[0] = 8'h60;
        data[2] = 8'h62;
        #1;
        tests++;
        if (ack !== 4'b0001) begin
            fails++;
            $display("FAIL mid_after_ack got %b want 0001", ack);
        end
        tick();
        tests++;
        if (out_sel !== 2'd0 || out_data !== 8'h60) begin
            fails++;
            $display("FAIL mid_after_out got %0d/%h want 0/60",
                     out_sel, out_data);
        end
        req = '0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req       = 4'($urandom);
            last      = 4'($urandom);
            data      = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            tests++;
            if (ack !== model_ack()) begin
                fails++;
                $display("FAIL rnd_ack cyc %0d got %b want %b",
                         k, ack, model_ack());
            end
            tick();
            tests++;
            if (out_valid !== m_ov || out_data !== m_od ||
                out_sel !== 2'(m_os) || out_last !== m_ol ||
                out_data_neg !== ~m_od) begin
                fails++;
                $display("FAIL rnd_out cyc %0d got %b/%h/%0d/%b want %b/%h/%0d/%b",
                         k, out_valid, out_data, out_sel, out_last,
                         m_ov, m_od, m_os, m_ol);
            end
        end
        req = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        last      = '0;
        data      = '0;
        out_ready = 1'b0;
        model_reset();
        test_reset();
        test_fair_rotation();
        test_packet_lock();
        test_backpressure();
        test_sparse_wrap();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
